// File: rtl/ssio_ddr_tx_framer.sv
// ---------------------------------------------------------------------------
// ssio_ddr_tx_framer
//
// Source-synchronous DDR transmit framer. Takes a 2*WIDTH-bit ready/valid
// frame stream from the MAC and produces per-edge register values for a
// downstream ODDR / differential output stage. Each stream word is split into
// a rising-edge half (low bits) and a falling-edge half (high bits).
//
// Each frame is sent as PREAMBLE_WORDS preamble words, then one SFD word,
// then the frame data. After the frame comes a gap of IFG_WORDS idle words.
// A per-word transmit error (s_tuser) is signalled by dropping the
// falling-edge control bit. This makes the wire see enable XOR error = 1 XOR 1.
// If the source runs dry mid-frame, the framer sends one error word. It then
// discards the rest of that frame up to tlast.
//
// Ports
//   clk              transmit clock, everything on the rising edge
//   rst              synchronous active-high reset
//   s_tdata          frame word (2*WIDTH bits)
//   s_tvalid         word valid
//   s_tready         word accepted when s_tvalid && s_tready
//   s_tlast          last word of frame
//   s_tuser          per-word transmit error
//   output_d_q1      rising-edge data  (word low half)
//   output_d_q2      falling-edge data (word high half)
//   output_ctl_q1    rising-edge control (enable)
//   output_ctl_q2    falling-edge control (enable XOR error)
//   output_clk_q1    forwarded clock pattern, rising half
//   output_clk_q2    forwarded clock pattern, falling half
//   status_frame     one-cycle pulse when a frame completes cleanly
//   status_underflow one-cycle pulse when the source underflows mid-frame
// ---------------------------------------------------------------------------
module ssio_ddr_tx_framer #(
    parameter int                   WIDTH          = 4,
    parameter int                   PREAMBLE_WORDS = 7,
    parameter logic [2*WIDTH-1:0]   PREAMBLE_WORD  = 8'h55,
    parameter logic [2*WIDTH-1:0]   SFD_WORD       = 8'hD5,
    parameter int                   IFG_WORDS      = 12
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [2*WIDTH-1:0]   s_tdata,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    input  logic                 s_tlast,
    input  logic                 s_tuser,

    output logic [WIDTH-1:0]     output_d_q1,
    output logic [WIDTH-1:0]     output_d_q2,
    output logic                 output_ctl_q1,
    output logic                 output_ctl_q2,
    output logic                 output_clk_q1,
    output logic                 output_clk_q2,

    output logic                 status_frame,
    output logic                 status_underflow
);

    // One counter serves both the preamble and the inter-frame gap. It is
    // sized to hold the larger of the two terminal counts, so it never wraps.
    localparam int CNT_MAX = (PREAMBLE_WORDS > IFG_WORDS) ? PREAMBLE_WORDS : IFG_WORDS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // The SFD state holds the final preamble word on the wire. That way, the
    // first data word is accepted in the cycle right after the SFD goes out,
    // and preamble, SFD and data form one unbroken burst.
    // PRE_LAST is the count of preamble words already sent at the point where
    // the last preamble word is loaded.
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_WORDS - 1);
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_WORDS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DATA,
        ST_DRAIN,
        ST_GAP
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;

    // The stream is only ever accepted in DATA and DRAIN. Decoding ready
    // straight from the state register keeps s_tvalid out of the ready path.
    assign s_tready = (state_q == ST_DATA) || (state_q == ST_DRAIN);

    // Single FSM block. Every output is a register that loads on the same
    // edge as the state transition that produces it.
    // The defaults at the top give an idle word (d = 0, ctl 0/0) and no
    // status pulses. Each state only overrides what differs from that.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            output_d_q1      <= '0;
            output_d_q2      <= '0;
            output_ctl_q1    <= 1'b0;
            output_ctl_q2    <= 1'b0;
            output_clk_q1    <= 1'b0;
            output_clk_q2    <= 1'b0;
            status_frame     <= 1'b0;
            status_underflow <= 1'b0;
        end else begin
            output_clk_q1    <= 1'b1;
            output_clk_q2    <= 1'b0;
            output_d_q1      <= '0;
            output_d_q2      <= '0;
            output_ctl_q1    <= 1'b0;
            output_ctl_q2    <= 1'b0;
            status_frame     <= 1'b0;
            status_underflow <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // A pending word starts the preamble. The word itself
                    // stays on the stream until DATA picks it up.
                    if (s_tvalid) begin
                        output_d_q1   <= PREAMBLE_WORD[WIDTH-1:0];
                        output_d_q2   <= PREAMBLE_WORD[2*WIDTH-1:WIDTH];
                        output_ctl_q1 <= 1'b1;
                        output_ctl_q2 <= 1'b1;
                        cnt_q         <= CNT_ONE;
                        state_q       <= (PREAMBLE_WORDS == 1) ? ST_SFD : ST_PREAMBLE;
                    end
                end

                ST_PREAMBLE: begin
                    output_d_q1   <= PREAMBLE_WORD[WIDTH-1:0];
                    output_d_q2   <= PREAMBLE_WORD[2*WIDTH-1:WIDTH];
                    output_ctl_q1 <= 1'b1;
                    output_ctl_q2 <= 1'b1;
                    cnt_q         <= cnt_q + CNT_ONE;
                    if (cnt_q == PRE_LAST) begin
                        state_q <= ST_SFD;
                    end
                end

                ST_SFD: begin
                    output_d_q1   <= SFD_WORD[WIDTH-1:0];
                    output_d_q2   <= SFD_WORD[2*WIDTH-1:WIDTH];
                    output_ctl_q1 <= 1'b1;
                    output_ctl_q2 <= 1'b1;
                    state_q       <= ST_DATA;
                end

                ST_DATA: begin
                    if (s_tvalid) begin
                        output_d_q1   <= s_tdata[WIDTH-1:0];
                        output_d_q2   <= s_tdata[2*WIDTH-1:WIDTH];
                        output_ctl_q1 <= 1'b1;
                        output_ctl_q2 <= ~s_tuser;
                        if (s_tlast) begin
                            status_frame <= 1'b1;
                            cnt_q        <= CNT_ONE;
                            state_q      <= ST_GAP;
                        end
                    end else begin
                        // Source ran dry mid-frame. Send a zero data word
                        // flagged as an error, then drop the rest of the frame.
                        output_ctl_q1    <= 1'b1;
                        output_ctl_q2    <= 1'b0;
                        status_underflow <= 1'b1;
                        state_q          <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    // Words are swallowed until the frame's tlast goes by.
                    if (s_tvalid && s_tlast) begin
                        cnt_q   <= CNT_ONE;
                        state_q <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    // The edge that enters GAP sets the count to 1. Each
                    // later GAP edge emits one idle word. The edge where the
                    // count reaches IFG_WORDS emits the last idle word and
                    // returns to IDLE.
                    if (cnt_q == IFG_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ssio_ddr_tx_framer.sv
// Self-checking bench for ssio_ddr_tx_framer.
// The stimulus tasks describe each frame at the word level. While driving,
// they push the output word the wire must carry after every edge onto a
// queue. A single compare process pops one entry per edge and checks it.
// A second instance with PREAMBLE_WORDS = 1 and IFG_WORDS = 1 is checked
// against hand-written literal values.
module tb_ssio_ddr_tx_framer;

   localparam int         PRE    = 7;
   localparam int         IFG    = 12;
   localparam logic [7:0] PRE_W  = 8'h55;
   localparam logic [7:0] SFD_W  = 8'hD5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [7:0] sTdata;
   logic       sTvalid;
   logic       sTready;
   logic       sTlast;
   logic       sTuser;
   logic [3:0] dQ1, dQ2;
   logic       ctlQ1, ctlQ2, clkQ1, clkQ2, statFrame, statUnder;

   ssio_ddr_tx_framer dut (
      .clk(clk), .rst(rst),
      .s_tdata(sTdata), .s_tvalid(sTvalid), .s_tready(sTready),
      .s_tlast(sTlast), .s_tuser(sTuser),
      .output_d_q1(dQ1), .output_d_q2(dQ2),
      .output_ctl_q1(ctlQ1), .output_ctl_q2(ctlQ2),
      .output_clk_q1(clkQ1), .output_clk_q2(clkQ2),
      .status_frame(statFrame), .status_underflow(statUnder)
   );

   // Small-parameter instance for the short preamble / short gap case
   logic       bRst, bValid, bReady, bLast, bUser;
   logic [7:0] bData;
   logic [3:0] bD1, bD2;
   logic       bC1, bC2, bK1, bK2, bFrame, bUnder;

   ssio_ddr_tx_framer #(.WIDTH(4), .PREAMBLE_WORDS(1), .PREAMBLE_WORD(8'h55),
                        .SFD_WORD(8'hD5), .IFG_WORDS(1)) dutSmall (
      .clk(clk), .rst(bRst),
      .s_tdata(bData), .s_tvalid(bValid), .s_tready(bReady),
      .s_tlast(bLast), .s_tuser(bUser),
      .output_d_q1(bD1), .output_d_q2(bD2),
      .output_ctl_q1(bC1), .output_ctl_q2(bC2),
      .output_clk_q1(bK1), .output_clk_q2(bK2),
      .status_frame(bFrame), .status_underflow(bUnder)
   );

   typedef struct packed {
      logic [3:0] d1;
      logic [3:0] d2;
      logic       c1;
      logic       c2;
      logic       k1;
      logic       k2;
      logic       frame;
      logic       under;
      logic       ready;
   } exp_t;

   exp_t       expQ[$];
   int         checks = 0;
   int         errors = 0;
   int         expFrames = 0;
   int         expUnders = 0;
   int         seenFrames = 0;
   int         seenUnders = 0;
   bit         smallDone = 1'b0;
   logic [7:0] frameData[16];
   bit         frameUser[16];

   // One comparison: counts it and reports a mismatch
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected wire word after a non-reset edge
   function automatic exp_t mk(input logic [7:0] w, input logic c1, input logic c2,
                               input logic fr, input logic un, input logic rd);
      exp_t e;
      e.d1 = w[3:0];
      e.d2 = w[7:4];
      e.c1 = c1;
      e.c2 = c2;
      e.k1 = 1'b1;
      e.k2 = 1'b0;
      e.frame = fr;
      e.under = un;
      e.ready = rd;
      return e;
   endfunction

   // Drives one cycle of inputs and records what the next edge must produce
   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l,
                                input logic u, input logic r, input exp_t e);
      @(negedge clk);
      rst     = r;
      sTvalid = v;
      sTdata  = d;
      sTlast  = l;
      sTuser  = u;
      expQ.push_back(e);
      @(posedge clk);
   endtask

   // Sends the frame held in frameData/frameUser.
   // underIdx >= 0 drops valid just before that word goes out.
   // gapMode picks s_tvalid during the gap: 0 low, 1 held high, 2 random.
   task automatic sendFrame(input int n, input int underIdx, input bit drainHoles,
                            input int gapMode, input bit pin);
      int   j;
      bit   drained;
      logic last;
      exp_t e;
      for (int i = 0; i < PRE; i++) begin
         applyStimulus(1'b1, frameData[0], n == 1, frameUser[0], 1'b0,
                       mk(PRE_W, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
         if (pin && i == 0) begin
            #1;
            checkOutput("pin_preamble_word", {dQ2, dQ1}, 8'h55);
         end
      end
      applyStimulus(1'b1, frameData[0], n == 1, frameUser[0], 1'b0,
                    mk(SFD_W, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
      if (pin) begin
         #1;
         checkOutput("pin_sfd_word", {dQ2, dQ1}, 8'hD5);
      end
      j = 0;
      drained = 1'b0;
      while (j < n) begin
         if (!drained && j == underIdx) begin
            applyStimulus(1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0,
                          mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
            drained = 1'b1;
         end else if (drained && drainHoles && $urandom_range(0, 2) == 0) begin
            applyStimulus(1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0,
                          mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
         end else begin
            last = (j == n - 1);
            if (drained)
               e = mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, !last);
            else
               e = mk(frameData[j], 1'b1, !frameUser[j], last, 1'b0, !last);
            applyStimulus(1'b1, frameData[j], last, frameUser[j], 1'b0, e);
            j++;
         end
      end
      if (drained) expUnders++;
      else         expFrames++;
      if (pin) begin
         #1;
         checkOutput("pin_last_d_q1", dQ1, 4'h6);
         checkOutput("pin_last_d_q2", dQ2, 4'h5);
         checkOutput("pin_last_frame", statFrame, 1'b1);
      end
      for (int g = 0; g < IFG; g++) begin
         applyStimulus((gapMode == 1) ? 1'b1 : (gapMode == 2) ? 1'($urandom) : 1'b0,
                       8'($urandom), 1'($urandom), 1'($urandom), 1'b0,
                       mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      end
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++)
         applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
   endtask

   // Four preamble words go out, then reset is sampled mid-preamble
   task automatic resetDuringPreamble();
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, mk(PRE_W, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
      applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, exp_t'(0));
   endtask

   // Compares the DUT against the expected word queue after every edge
   initial begin : compareProc
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (statFrame === 1'b1) seenFrames++;
         if (statUnder === 1'b1) seenUnders++;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("d_q1", dQ1, e.d1);
            checkOutput("d_q2", dQ2, e.d2);
            checkOutput("ctl_q1", ctlQ1, e.c1);
            checkOutput("ctl_q2", ctlQ2, e.c2);
            checkOutput("clk_q1", clkQ1, e.k1);
            checkOutput("clk_q2", clkQ2, e.k2);
            checkOutput("status_frame", statFrame, e.frame);
            checkOutput("status_underflow", statUnder, e.under);
            checkOutput("s_tready", sTready, e.ready);
         end
      end
   end

   // Literal walk-through: 1 preamble, SFD, data 0xA5, 1 gap word, idle
   initial begin : smallParamTest
      bRst = 1'b1; bValid = 1'b0; bData = 8'h00; bLast = 1'b0; bUser = 1'b0;
      repeat (2) @(negedge clk);
      bRst = 1'b0;
      @(negedge clk);
      bValid = 1'b1; bData = 8'hA5; bLast = 1'b1;
      @(posedge clk); #1;
      checkOutput("small_e0_word", {bD2, bD1}, 8'h55);
      checkOutput("small_e0_ctl", {bC1, bC2}, 2'b11);
      checkOutput("small_e0_ready", bReady, 1'b0);
      @(posedge clk); #1;
      checkOutput("small_e1_word", {bD2, bD1}, 8'hD5);
      checkOutput("small_e1_ready", bReady, 1'b1);
      @(posedge clk); #1;
      checkOutput("small_e2_word", {bD2, bD1}, 8'hA5);
      checkOutput("small_e2_ctl", {bC1, bC2}, 2'b11);
      checkOutput("small_e2_frame", bFrame, 1'b1);
      checkOutput("small_e2_ready", bReady, 1'b0);
      @(negedge clk);
      bValid = 1'b0; bLast = 1'b0;
      @(posedge clk); #1;
      checkOutput("small_e3_gap", {bC1, bC2, bD2, bD1}, 10'h000);
      checkOutput("small_e3_clk", {bK1, bK2}, 2'b10);
      @(posedge clk); #1;
      checkOutput("small_e4_idle", {bC1, bC2, bD2, bD1, bReady}, 11'h000);
      smallDone = 1'b1;
   end

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : mainStim
      int n, u, gapMode, idleN;
      rst = 1'b1; sTvalid = 1'b0; sTdata = 8'h00; sTlast = 1'b0; sTuser = 1'b0;
      repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, exp_t'(0));
      idleCycles(2);

      // 3-word frame, clean
      frameData[0] = 8'h12; frameData[1] = 8'h34; frameData[2] = 8'h56;
      frameUser[0] = 0; frameUser[1] = 0; frameUser[2] = 0;
      sendFrame(3, -1, 1'b0, 0, 1'b1);
      idleCycles(1);

      // Same frame with an error on word 2, valid held through the gap
      frameUser[1] = 1;
      sendFrame(3, -1, 1'b0, 1, 1'b0);
      frameData[0] = 8'hA1; frameData[1] = 8'hB2;
      frameUser[0] = 0; frameUser[1] = 0;
      sendFrame(2, -1, 1'b0, 0, 1'b0);
      idleCycles(2);

      // Underflow after word 1 of a 4-word frame
      frameData[0] = 8'h01; frameData[1] = 8'h02; frameData[2] = 8'h03; frameData[3] = 8'h04;
      for (int i = 0; i < 4; i++) frameUser[i] = 0;
      sendFrame(4, 1, 1'b0, 0, 1'b0);
      idleCycles(1);

      // Reset mid-preamble, then an immediate new frame
      resetDuringPreamble();
      frameData[0] = 8'h77; frameData[1] = 8'h88;
      frameUser[0] = 0; frameUser[1] = 0;
      sendFrame(2, -1, 1'b0, 0, 1'b0);

      // Randomized frames
      for (int f = 0; f < 30; f++) begin
         n = $urandom_range(1, 6);
         for (int j = 0; j < n; j++) begin
            frameData[j] = 8'($urandom);
            frameUser[j] = ($urandom_range(0, 3) == 0);
         end
         u = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
         gapMode = $urandom_range(0, 2);
         idleN = $urandom_range(0, 2);
         sendFrame(n, u, 1'b1, gapMode, 1'b0);
         idleCycles(idleN);
      end

      idleCycles(2);
      wait (smallDone);
      @(posedge clk);
      #2;
      checkOutput("frame_pulse_count", seenFrames, expFrames);
      checkOutput("underflow_pulse_count", seenUnders, expUnders);
      checkOutput("queue_drained", expQ.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
